// File: rtl/crg_uart_pkg.sv
// Shared opcodes, parser state encoding and error codes for the UART command path.
package crg_uart_pkg;
  localparam logic [7:0] OP_SET_KEY = 8'h10;
  localparam logic [7:0] OP_SET_PT  = 8'h20;
  localparam logic [7:0] OP_RUN     = 8'h40;

  localparam logic [1:0] ERR_OPC = 2'd1;
  localparam logic [1:0] ERR_OVR = 2'd2;
  localparam logic [1:0] ERR_TMO = 2'd3;

  typedef enum logic [1:0] {IDLE, ADDR, DATA, HOLD} state_t;
endpackage

// File: rtl/uart_cmd_parser.sv
// Assembles UART host frames (cmd, addr, payload LSB-first) into one valid/ready command.
// Optional inter-byte timeout is built when UART_CMD_TIMEOUT_EN is defined.
module uart_cmd_parser
  import crg_uart_pkg::*;
#(
  parameter int N_BYTES     = 16,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [7:0]           rx_data,
  input  logic                 rx_valid,
  output logic                 cmd_valid,
  input  logic                 cmd_ready,
  output logic [7:0]           cmd_op,
  output logic [7:0]           cmd_addr,
  output logic [8*N_BYTES-1:0] cmd_data,
  output logic                 busy,
  output logic                 err,
  output logic [1:0]           err_code
);
  localparam int CW = $clog2(N_BYTES) + 1;
  localparam logic [CW-1:0] LAST = CW'(N_BYTES - 1);

  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic          err_nx;
  logic [1:0]    code_nx;
  logic          tmo_hit;

`ifdef UART_CMD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [TW-1:0] TMO_LIM = TW'(TIMEOUT_CYC - 1);
  logic [TW-1:0] tmo;
  logic          in_frame;

  assign in_frame = (state == ADDR) || (state == DATA);
  // a byte arriving on the limit cycle still counts as in time
  assign tmo_hit  = in_frame && !rx_valid && (tmo == TMO_LIM);

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)                   tmo <= '0;
    else if (!in_frame || rx_valid) tmo <= '0;
    else                          tmo <= tmo + 1'b1;
`else
  // timeout not built; expression only keeps TIMEOUT_CYC referenced
  assign tmo_hit = (TIMEOUT_CYC < 1);
`endif

  always_comb begin
    state_nx = state;
    err_nx   = 1'b0;
    code_nx  = err_code;
    case (state)
      IDLE: if (rx_valid) begin
        if (rx_data == OP_SET_KEY || rx_data == OP_SET_PT) state_nx = ADDR;
        else if (rx_data == OP_RUN)                        state_nx = HOLD;
        else begin
          err_nx  = 1'b1;
          code_nx = ERR_OPC;
        end
      end
      ADDR: if (rx_valid) state_nx = DATA;
      DATA: if (rx_valid && cnt == LAST) state_nx = HOLD;
      HOLD: begin
        // a byte here is dropped even if the handshake completes this cycle
        if (rx_valid) begin
          err_nx  = 1'b1;
          code_nx = ERR_OVR;
        end
        if (cmd_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    if (tmo_hit) begin
      state_nx = IDLE;
      err_nx   = 1'b1;
      code_nx  = ERR_TMO;
    end
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= IDLE;
      cmd_valid <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
      err_code  <= 2'd0;
    end else begin
      state     <= state_nx;
      cmd_valid <= (state_nx == HOLD);
      busy      <= (state_nx != IDLE);
      err       <= err_nx;
      err_code  <= code_nx;
    end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cmd_op   <= 8'h00;
      cmd_addr <= 8'h00;
      cmd_data <= '0;
      cnt      <= '0;
    end else if (rx_valid) begin
      case (state)
        IDLE: begin
          if (rx_data == OP_SET_KEY || rx_data == OP_SET_PT) begin
            cmd_op   <= rx_data;
            cmd_data <= '0;
            cnt      <= '0;
          end else if (rx_data == OP_RUN) begin
            cmd_op   <= rx_data;
            cmd_addr <= 8'h00;
          end
        end
        ADDR: cmd_addr <= rx_data;
        DATA: begin
          cmd_data <= {rx_data, cmd_data[8*N_BYTES-1:8]};
          cnt      <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser: frame scoreboard and error-code scoreboard.
// The timeout step exercises UART_CMD_TIMEOUT_EN when that macro is defined.
module tb_uart_cmd_parser;
  localparam int NB  = 16;
  localparam int TMO = 1000;

  typedef struct {
    logic [7:0]      op;
    logic [7:0]      addr;
    logic [8*NB-1:0] data;
    logic            chk_data;
  } frame_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [7:0]      rx_data;
  logic            rx_valid;
  logic            cmd_valid;
  logic            cmd_ready;
  logic [7:0]      cmd_op;
  logic [7:0]      cmd_addr;
  logic [8*NB-1:0] cmd_data;
  logic            busy;
  logic            err;
  logic [1:0]      err_code;

  int tests = 0;
  int fails = 0;
  int vcyc  = 0;
  frame_t     fq[$];
  logic [1:0] eq[$];

  uart_cmd_parser #(.N_BYTES(NB), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .busy(busy), .err(err),
    .err_code(err_code)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    assert (act === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // handshakes and error pulses are sampled mid-cycle and matched against the queues
  always @(negedge clk) begin
    if (rst_n) begin
      if (cmd_valid) vcyc++;
      if (cmd_valid && cmd_ready) begin
        if (fq.size() == 0) chk("unexpected_frame", 128'(cmd_op), 128'hffff);
        else begin
          frame_t f;
          f = fq.pop_front();
          chk("frame_op", 128'(cmd_op), 128'(f.op));
          chk("frame_addr", 128'(cmd_addr), 128'(f.addr));
          if (f.chk_data) chk("frame_data", cmd_data, f.data);
        end
      end
      if (err) begin
        if (eq.size() == 0) chk("unexpected_err", 128'(err_code), 128'h0);
        else chk("err_code", 128'(err_code), 128'(eq.pop_front()));
      end
    end
  end

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] op, input logic [7:0] addr,
                            input logic [127:0] data, input int nbytes);
    send(op);
    send(addr);
    for (int i = 0; i < nbytes; i++) send(data[8*i +: 8]);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk(tag, 128'(busy), 128'h0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"}, 128'(cmd_valid), 128'h0);
    chk({tag, "_op"},    128'(cmd_op),    128'h0);
    chk({tag, "_addr"},  128'(cmd_addr),  128'h0);
    chk({tag, "_data"},  cmd_data,        128'h0);
    chk({tag, "_busy"},  128'(busy),      128'h0);
    chk({tag, "_err"},   128'({err, err_code}), 128'h0);
  endtask

  initial begin
    logic [127:0] key, pt, pt2;
    int v0, n;
    key = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    pt  = {$urandom, $urandom, $urandom, $urandom};
    pt2 = {$urandom, $urandom, $urandom, $urandom};
    rst_n = 1'b0; rx_data = 8'h00; rx_valid = 1'b0; cmd_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;

    // key load with ready already high: one valid cycle
    cmd_ready = 1'b1;
    fq.push_back('{8'h10, 8'h00, key, 1'b1});
    v0 = vcyc;
    send_frame(8'h10, 8'h00, key, NB);
    wait_idle("key_idle");
    @(negedge clk);
    chk("key_valid_cycles", 128'(vcyc - v0), 128'd1);

    // RUN: valid the cycle after its byte, idle after the handshake
    fq.push_back('{8'h40, 8'h00, '0, 1'b0});
    send(8'h40);
    chk("run_valid", 128'(cmd_valid), 128'h1);
    @(negedge clk);
    chk("run_busy_after", 128'(busy), 128'h0);

    // backpressure, then an overrun byte that must not disturb the pending frame
    cmd_ready = 1'b0;
    fq.push_back('{8'h20, 8'h05, pt, 1'b1});
    send_frame(8'h20, 8'h05, pt, NB);
    chk("bp_valid", 128'(cmd_valid), 128'h1);
    chk("bp_busy", 128'(busy), 128'h1);
    eq.push_back(2'd2);
    send(8'h55);
    repeat (2) @(negedge clk);
    chk("ovr_data_kept", cmd_data, pt);
    chk("ovr_valid_kept", 128'(cmd_valid), 128'h1);
    chk("ovr_code_held", 128'(err_code), 128'h2);
    cmd_ready = 1'b1;
    wait_idle("bp_idle");

    // handshake and byte in the same cycle: byte is an overrun, next byte parses from IDLE
    cmd_ready = 1'b0;
    fq.push_back('{8'h10, 8'ha5, pt2, 1'b1});
    send_frame(8'h10, 8'ha5, pt2, NB);
    eq.push_back(2'd2);
    @(negedge clk);
    cmd_ready = 1'b1; rx_data = 8'h40; rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    chk("same_cycle_idle", 128'(busy), 128'h0);
    fq.push_back('{8'h40, 8'h00, '0, 1'b0});
    send(8'h40);
    wait_idle("same_cycle_run_idle");

    // unknown opcode stays idle, then a normal RUN
    eq.push_back(2'd1);
    send(8'h33);
    chk("opc_busy", 128'(busy), 128'h0);
    chk("opc_err_pulse", 128'({err, err_code}), 128'h5);
    fq.push_back('{8'h40, 8'h00, '0, 1'b0});
    send(8'h40);
    wait_idle("opc_run_idle");
    @(negedge clk);
    chk("opc_code_held", 128'(err_code), 128'h1);

    // stall mid-payload
    v0 = vcyc;
    send_frame(8'h10, 8'h00, key, 5);
`ifdef UART_CMD_TIMEOUT_EN
    eq.push_back(2'd3);
    n = 0;
    while (!err && n < TMO + 100) begin
      @(negedge clk);
      n++;
    end
    chk("tmo_latency", 128'(n), 128'(TMO));
    chk("tmo_busy", 128'(busy), 128'h0);
    chk("tmo_no_valid", 128'(vcyc - v0), 128'h0);
    @(negedge clk);
    chk("tmo_code_held", 128'(err_code), 128'h3);
`else
    repeat (TMO + 100) @(negedge clk);
    chk("no_tmo_busy", 128'(busy), 128'h1);
    chk("no_tmo_code", 128'(err_code), 128'h1);
    chk("no_tmo_no_valid", 128'(vcyc - v0), 128'h0);
`endif

    // reset mid-frame, then a clean key frame
    send_frame(8'h10, 8'h00, key, 8);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk_reset_outputs("midrst");
    rst_n = 1'b1;
    fq.push_back('{8'h10, 8'h01, key, 1'b1});
    send_frame(8'h10, 8'h01, key, NB);
    wait_idle("midrst_idle");
    repeat (2) @(negedge clk);

    chk("frames_left", 128'(fq.size()), 128'h0);
    chk("errs_left", 128'(eq.size()), 128'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
